rom_arbiter: RTL and testbench

Two-port arbiter and sequencer for the 256 x 16 instruction/constant ROM. It shares the single combinational ROM read port between the instruction-fetch path (port 0) and the data-load path (port 1). Each request uses a valid/ready handshake, and each read returns a registered one-cycle response pulse. It sits between the core's fetch/load units and the `rom` instance, and owns the ROM `address` input.

---
 rtl/rom_arbiter_pkg.sv | 19 +
 rtl/rom_arb_pick.sv | 22 ++
 rtl/rom_arbiter.sv | 128 ++++++++++++
 tb/tb_rom_arbiter.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_arbiter_pkg.sv
// Shared constants and state encoding for rom_arbiter.
// Optional feature macro: ROM_ARB_ROUND_ROBIN_EN (round-robin instead of fixed priority).
`ifndef ROM_ARBITER_PKG_SV
`define ROM_ARBITER_PKG_SV
package rom_arbiter_pkg;

  localparam int unsigned ADDR_W_DEF = 8;
  localparam int unsigned DATA_W_DEF = 16;

  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_LOAD  = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_READ = 1'b1
  } state_e;

endpackage
`endif

// File: rtl/rom_arb_pick.sv
// Combinational two-way picker: pointer breaks ties, a lone valid port always wins.
module rom_arb_pick
  import rom_arbiter_pkg::*;
(
  input  logic       valid0_i,
  input  logic       valid1_i,
  input  logic       ptr_i,
  output logic [1:0] grant_c
);

  always_comb begin
    grant_c = 2'b00;
    if (valid0_i && valid1_i) begin
      grant_c = (ptr_i == PORT_LOAD) ? 2'b10 : 2'b01;
    end else if (valid0_i) begin
      grant_c = 2'b01;
    end else if (valid1_i) begin
      grant_c = 2'b10;
    end
  end

endmodule

// File: rtl/rom_arbiter.sv
// Two-port fetch/load arbiter and sequencer for the shared combinational ROM read port.
// ROM_ARB_ROUND_ROBIN_EN selects round-robin arbitration; otherwise fetch has fixed priority.
module rom_arbiter
  import rom_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  output logic              req0_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_data,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  output logic              req1_ready,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_data,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [DATA_W-1:0] rom_data,
  output logic              busy
);

  state_e            state_q, state_d;
  logic              port_q, port_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic              rsp0_valid_q, rsp0_valid_d;
  logic              rsp1_valid_q, rsp1_valid_d;
  logic [DATA_W-1:0] rsp0_data_q, rsp0_data_d;
  logic [DATA_W-1:0] rsp1_data_q, rsp1_data_d;
  logic              ready0_c, ready1_c;
  logic [1:0]        grant_c;
  logic              ptr;

`ifdef ROM_ARB_ROUND_ROBIN_EN
  logic ptr_q, ptr_d;
  assign ptr = ptr_q;
`else
  assign ptr = PORT_FETCH;
`endif

  rom_arb_pick u_pick (
    .valid0_i (req0_valid),
    .valid1_i (req1_valid),
    .ptr_i    (ptr),
    .grant_c  (grant_c)
  );

  // Next-state, datapath and handshake decode.
  always_comb begin
    state_d      = state_q;
    port_d       = port_q;
    rom_addr_d   = rom_addr_q;
    rsp0_valid_d = 1'b0;
    rsp1_valid_d = 1'b0;
    rsp0_data_d  = rsp0_data_q;
    rsp1_data_d  = rsp1_data_q;
    ready0_c     = 1'b0;
    ready1_c     = 1'b0;
`ifdef ROM_ARB_ROUND_ROBIN_EN
    ptr_d        = ptr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        ready0_c = grant_c[0];
        ready1_c = grant_c[1];
        if (|grant_c) begin
          state_d    = ST_READ;
          port_d     = grant_c[1];
          rom_addr_d = grant_c[1] ? req1_addr : req0_addr;
`ifdef ROM_ARB_ROUND_ROBIN_EN
          ptr_d      = ~grant_c[1];
`endif
        end
      end
      ST_READ: begin
        state_d = ST_IDLE;
        if (port_q == PORT_LOAD) begin
          rsp1_valid_d = 1'b1;
          rsp1_data_d  = rom_data;
        end else begin
          rsp0_valid_d = 1'b1;
          rsp0_data_d  = rom_data;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      port_q       <= PORT_FETCH;
      rom_addr_q   <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_data_q  <= '0;
      rsp1_data_q  <= '0;
`ifdef ROM_ARB_ROUND_ROBIN_EN
      ptr_q        <= PORT_FETCH;
`endif
    end else begin
      state_q      <= state_d;
      port_q       <= port_d;
      rom_addr_q   <= rom_addr_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp0_data_q  <= rsp0_data_d;
      rsp1_data_q  <= rsp1_data_d;
`ifdef ROM_ARB_ROUND_ROBIN_EN
      ptr_q        <= ptr_d;
`endif
    end
  end

  // Ready is an IDLE-only combinational grant, forced low while reset is held.
  assign req0_ready  = ready0_c & reset_n;
  assign req1_ready  = ready1_c & reset_n;
  assign rsp0_valid  = rsp0_valid_q;
  assign rsp1_valid  = rsp1_valid_q;
  assign rsp0_data   = rsp0_data_q;
  assign rsp1_data   = rsp1_data_q;
  assign rom_address = rom_addr_q;
  assign busy        = (state_q == ST_READ);

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed self-checking bench for rom_arbiter with a {a, ~a} ROM model.
module tb_rom_arbiter;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [7:0]  req0_addr = 8'h00, req1_addr = 8'h00;
  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy;
  logic [15:0] rsp0_data, rsp1_data, rom_data;
  logic [7:0]  rom_address;

  int checks = 0;
  int errors = 0;

`ifdef ROM_ARB_ROUND_ROBIN_EN
  localparam logic [1:0] EXP_SECOND = 2'b10;
`else
  localparam logic [1:0] EXP_SECOND = 2'b01;
`endif

  rom_arbiter dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req0_valid  (req0_valid),
    .req0_addr   (req0_addr),
    .req0_ready  (req0_ready),
    .rsp0_valid  (rsp0_valid),
    .rsp0_data   (rsp0_data),
    .req1_valid  (req1_valid),
    .req1_addr   (req1_addr),
    .req1_ready  (req1_ready),
    .rsp1_valid  (rsp1_valid),
    .rsp1_data   (rsp1_data),
    .rom_address (rom_address),
    .rom_data    (rom_data),
    .busy        (busy)
  );

  assign rom_data = {rom_address, ~rom_address};

  always #5 clock = ~clock;

  function automatic logic [15:0] rom_word(input logic [7:0] a);
    return {a, ~a};
  endfunction

  task automatic step();
    @(negedge clock);
  endtask

  task automatic do_reset();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    reset_n    = 1'b0;
    step();
    step();
    reset_n    = 1'b1;
  endtask

  task automatic test_reset();
    #2 reset_n = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    step();
    #1;
    checks++;
    if ({req1_ready, req0_ready} !== 2'b00) begin
      errors++; $display("FAIL reset_ready: got %b expected 00", {req1_ready, req0_ready});
    end
    checks++;
    if ({rsp1_valid, rsp0_valid, busy} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got %b expected 000", {rsp1_valid, rsp0_valid, busy});
    end
    checks++;
    if ({rsp0_data, rsp1_data, rom_address} !== 40'h0) begin
      errors++; $display("FAIL reset_data: got %h expected 0", {rsp0_data, rsp1_data, rom_address});
    end
    do_reset();
  endtask

  task automatic test_single_fetch();
    do_reset();
    req0_addr  = 8'h12;
    req0_valid = 1'b1;
    #1;
    checks++;
    if ({req1_ready, req0_ready, busy} !== 3'b010) begin
      errors++; $display("FAIL fetch_c0: got %b expected 010", {req1_ready, req0_ready, busy});
    end
    step();
    req0_valid = 1'b0;
    #1;
    checks++;
    if ({busy, req0_ready, rsp0_valid, rom_address} !== {3'b100, 8'h12}) begin
      errors++; $display("FAIL fetch_c1: got %b/%h expected 100/12", {busy, req0_ready, rsp0_valid}, rom_address);
    end
    step();
    #1;
    checks++;
    if ({rsp0_valid, rsp1_valid, busy} !== 3'b100 || rsp0_data !== 16'h12ED) begin
      errors++; $display("FAIL fetch_c2: got %b/%h expected 100/12ed", {rsp0_valid, rsp1_valid, busy}, rsp0_data);
    end
    step();
    #1;
    checks++;
    if (rsp0_valid !== 1'b0 || rsp0_data !== 16'h12ED || rom_address !== 8'h12) begin
      errors++; $display("FAIL fetch_hold: got %b/%h/%h expected 0/12ed/12", rsp0_valid, rsp0_data, rom_address);
    end
  endtask

  task automatic test_simultaneous();
    logic [1:0] exp_g [3];
    logic [7:0] exp_a;
    exp_g[0] = 2'b01;
    exp_g[1] = EXP_SECOND;
    exp_g[2] = 2'b01;
    do_reset();
    req0_addr  = 8'h01;
    req1_addr  = 8'h02;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if ({req1_ready, req0_ready} !== exp_g[k]) begin
        errors++; $display("FAIL sim_grant%0d: got %b expected %b", k, {req1_ready, req0_ready}, exp_g[k]);
      end
      if (k > 0) begin
        checks++;
        if ({rsp1_valid, rsp0_valid} !== exp_g[k-1] ||
            (exp_g[k-1] == 2'b10 ? rsp1_data : rsp0_data) !== (exp_g[k-1] == 2'b10 ? 16'h02FD : 16'h01FE)) begin
          errors++; $display("FAIL sim_rsp%0d: got %b/%h/%h expected %b", k - 1, {rsp1_valid, rsp0_valid}, rsp0_data, rsp1_data, exp_g[k-1]);
        end
      end
      exp_a = (exp_g[k] == 2'b10) ? 8'h02 : 8'h01;
      step();
      #1;
      checks++;
      if (busy !== 1'b1 || rom_address !== exp_a || {req1_ready, req0_ready} !== 2'b00) begin
        errors++; $display("FAIL sim_read%0d: got %b/%h expected 1/%h", k, busy, rom_address, exp_a);
      end
      step();
    end
    req0_valid = 1'b0;
    #1;
    checks++;
    if ({rsp1_valid, rsp0_valid} !== 2'b01 || rsp0_data !== 16'h01FE) begin
      errors++; $display("FAIL sim_rsp2: got %b/%h expected 01/01fe", {rsp1_valid, rsp0_valid}, rsp0_data);
    end
    checks++;
    if ({req1_ready, req0_ready} !== 2'b10) begin
      errors++; $display("FAIL sim_port1_after_drop: got %b expected 10", {req1_ready, req0_ready});
    end
    step();
    req1_valid = 1'b0;
    #1;
    checks++;
    if (rom_address !== 8'h02) begin
      errors++; $display("FAIL sim_port1_addr: got %h expected 02", rom_address);
    end
    step();
    #1;
    checks++;
    if (rsp1_valid !== 1'b1 || rsp1_data !== rom_word(8'h02)) begin
      errors++; $display("FAIL sim_port1_rsp: got %b/%h expected 1/02fd", rsp1_valid, rsp1_data);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    req1_addr  = 8'hFF;
    req1_valid = 1'b1;
    #1;
    checks++;
    if ({req1_ready, req0_ready} !== 2'b10) begin
      errors++; $display("FAIL b2b_grant0: got %b expected 10", {req1_ready, req0_ready});
    end
    step();
    req1_addr = 8'h00;
    #1;
    checks++;
    if (busy !== 1'b1 || rom_address !== 8'hFF || rsp1_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_read0: got %b/%h/%b expected 1/ff/0", busy, rom_address, rsp1_valid);
    end
    step();
    #1;
    checks++;
    if (rsp1_valid !== 1'b1 || rsp1_data !== 16'hFF00 || req1_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_rsp0: got %b/%h/%b expected 1/ff00/1", rsp1_valid, rsp1_data, req1_ready);
    end
    step();
    req1_valid = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b1 || rom_address !== 8'h00 || rsp1_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_read1: got %b/%h/%b expected 1/00/0", busy, rom_address, rsp1_valid);
    end
    step();
    #1;
    checks++;
    if (rsp1_valid !== 1'b1 || rsp1_data !== 16'h00FF || rsp0_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_rsp1: got %b/%h expected 1/00ff", rsp1_valid, rsp1_data);
    end
    step();
  endtask

  task automatic test_reset_in_read();
    req0_addr  = 8'h34;
    req0_valid = 1'b1;
    #1;
    checks++;
    if (req0_ready !== 1'b1) begin
      errors++; $display("FAIL rir_grant: got %b expected 1", req0_ready);
    end
    step();
    req0_valid = 1'b0;
    reset_n    = 1'b0;
    #1;
    checks++;
    if ({busy, rsp0_valid, rsp1_valid, req0_ready, req1_ready} !== 5'b0 ||
        {rsp0_data, rsp1_data, rom_address} !== 40'h0) begin
      errors++; $display("FAIL rir_cleared: got %b/%h/%h/%h expected all 0",
                         {busy, rsp0_valid, rsp1_valid, req0_ready, req1_ready}, rsp0_data, rsp1_data, rom_address);
    end
    step();
    reset_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++;
      if ({rsp0_valid, rsp1_valid, busy} !== 3'b000) begin
        errors++; $display("FAIL rir_no_pulse%0d: got %b expected 000", k, {rsp0_valid, rsp1_valid, busy});
      end
      step();
    end
    req0_addr  = 8'h56;
    req0_valid = 1'b1;
    #1;
    checks++;
    if (req0_ready !== 1'b1) begin
      errors++; $display("FAIL rir_regrant: got %b expected 1", req0_ready);
    end
    step();
    req0_valid = 1'b0;
    step();
    #1;
    checks++;
    if (rsp0_valid !== 1'b1 || rsp0_data !== rom_word(8'h56)) begin
      errors++; $display("FAIL rir_after: got %b/%h expected 1/56a9", rsp0_valid, rsp0_data);
    end
  endtask

  task automatic test_withdrawn();
    do_reset();
    req0_addr  = 8'h10;
    req1_addr  = 8'h20;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    checks++;
    if ({req1_ready, req0_ready} !== 2'b01) begin
      errors++; $display("FAIL wd_grant: got %b expected 01", {req1_ready, req0_ready});
    end
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if (rsp1_valid !== 1'b0 || req1_ready !== 1'b0) begin
        errors++; $display("FAIL wd_port1_%0d: got rsp %b ready %b expected 0 0", k, rsp1_valid, req1_ready);
      end
      if (k == 1) begin
        checks++;
        if (rsp0_valid !== 1'b1 || rsp0_data !== 16'h10EF) begin
          errors++; $display("FAIL wd_port0_rsp: got %b/%h expected 1/10ef", rsp0_valid, rsp0_data);
        end
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_simultaneous();
    test_back_to_back();
    test_reset_in_read();
    test_withdrawn();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
